cpu_decode: RTL and testbench

//  Moxie decode stage. Takes 16-bit instruction halfwords from fetch over a valid/ready handshake.

---
 rtl/cpu_decode_pkg.sv | 50 +++++
 rtl/cpu_decode_if.sv | 11 +
 rtl/cpu_decode.sv | 120 ++++++++++++
 tb/tb_cpu_decode.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_decode_pkg.sv
// Shared encodings, FSM states and the decode-result payload for the Moxie decode stage.
package cpu_decode_pkg;

  localparam int unsigned INSN_W    = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned SHORT_W   = 8;

  localparam logic [7:0] OP_LDI_L = 8'h01;
  localparam logic [7:0] OP_NOP   = 8'h0f;
  localparam logic [3:0] F2_INC   = 4'h8;
  localparam logic [3:0] F2_DEC   = 4'h9;

  typedef enum logic [1:0] {
    ST_OPC    = 2'd0,
    ST_IMM_HI = 2'd1,
    ST_IMM_LO = 2'd2
  } state_e;

  typedef struct packed {
    logic                 op_ldi;
    logic                 op_dec;
    logic                 op_nop;
    logic                 illegal;
    logic [REG_IDX_W-1:0] rd_idx;
    logic [REG_IDX_W-1:0] rs_idx;
    logic [OPERAND_W-1:0] operand;
  } dec_out_t;

  localparam dec_out_t DEC_OUT_RST = '{
    op_ldi:  1'b0,
    op_dec:  1'b0,
    op_nop:  1'b1,
    illegal: 1'b0,
    rd_idx:  '0,
    rs_idx:  '0,
    operand: '0
  };

  // Form-2 ops read and write the same register and carry an 8-bit zero-extended operand.
  function automatic dec_out_t form2_fields(input dec_out_t prev, input logic [INSN_W-1:0] insn);
    dec_out_t o;
    o         = prev;
    o.rd_idx  = insn[11:8];
    o.rs_idx  = insn[11:8];
    o.operand = OPERAND_W'(insn[SHORT_W-1:0]);
    return o;
  endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Fetch-to-decode halfword handshake (valid/ready).
interface cpu_decode_if;
  import cpu_decode_pkg::*;

  logic [INSN_W-1:0] insn;
  logic              insn_valid;
  logic              insn_ready;

  modport master (output insn, output insn_valid, input  insn_ready);
  modport slave  (input  insn, input  insn_valid, output insn_ready);
endinterface

// File: rtl/cpu_decode.sv
// Moxie decode stage: assembles 48-bit ldi.l and decodes short ops into registered strobes.
// Optional feature: define CPU_DECODE_INC_EN to decode form-2 inc onto op_inc_o.
module cpu_decode
  import cpu_decode_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  cpu_decode_if.slave          fetch,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [REG_IDX_W-1:0] register_read_index_o,
  output logic [REG_IDX_W-1:0] register_write_index_o,
  output logic [OPERAND_W-1:0] operand_o,
  output logic                 op_ldi_o,
  output logic                 op_dec_o,
  output logic                 op_nop_o,
`ifdef CPU_DECODE_INC_EN
  output logic                 op_inc_o,
`endif
  output logic                 illegal_o
);

  state_e            state_q, state_d;
  logic [15:0]       imm_hi_q, imm_hi_d;
  logic [REG_IDX_W-1:0] ra_q, ra_d;
  dec_out_t          out_q, out_d;
  logic              accept;
`ifdef CPU_DECODE_INC_EN
  logic              inc_q, inc_d;
`endif

  assign fetch.insn_ready = !rst_i && !stall_i && !flush_i;
  assign accept           = fetch.insn_valid && fetch.insn_ready;

  // Next state and next output word; a cycle without a completed instruction is a nop.
  always_comb begin
    state_d        = state_q;
    imm_hi_d       = imm_hi_q;
    ra_d           = ra_q;
    out_d          = out_q;
    out_d.op_ldi   = 1'b0;
    out_d.op_dec   = 1'b0;
    out_d.illegal  = 1'b0;
    out_d.op_nop   = 1'b1;
`ifdef CPU_DECODE_INC_EN
    inc_d          = 1'b0;
`endif
    if (flush_i) begin
      state_d = ST_OPC;
    end else if (accept) begin
      case (state_q)
        ST_OPC: begin
          if (fetch.insn[15:8] == OP_LDI_L) begin
            ra_d    = fetch.insn[7:4];
            state_d = ST_IMM_HI;
          end else if (fetch.insn[15:8] == OP_NOP) begin
            out_d.op_nop = 1'b1;
          end else if (fetch.insn[15:12] == F2_DEC) begin
            out_d        = form2_fields(out_d, fetch.insn);
            out_d.op_dec = 1'b1;
            out_d.op_nop = 1'b0;
`ifdef CPU_DECODE_INC_EN
          end else if (fetch.insn[15:12] == F2_INC) begin
            out_d        = form2_fields(out_d, fetch.insn);
            inc_d        = 1'b1;
            out_d.op_nop = 1'b0;
`endif
          end else begin
            out_d.illegal = 1'b1;
          end
        end
        ST_IMM_HI: begin
          imm_hi_d = fetch.insn;
          state_d  = ST_IMM_LO;
        end
        ST_IMM_LO: begin
          out_d.operand = {imm_hi_q, fetch.insn};
          out_d.rd_idx  = ra_q;
          out_d.rs_idx  = ra_q;
          out_d.op_ldi  = 1'b1;
          out_d.op_nop  = 1'b0;
          state_d       = ST_OPC;
        end
        default: state_d = ST_OPC;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_OPC;
      imm_hi_q <= '0;
      ra_q     <= '0;
      out_q    <= DEC_OUT_RST;
`ifdef CPU_DECODE_INC_EN
      inc_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      imm_hi_q <= imm_hi_d;
      ra_q     <= ra_d;
      out_q    <= out_d;
`ifdef CPU_DECODE_INC_EN
      inc_q    <= inc_d;
`endif
    end
  end

  assign register_read_index_o  = out_q.rs_idx;
  assign register_write_index_o = out_q.rd_idx;
  assign operand_o              = out_q.operand;
  assign op_ldi_o               = out_q.op_ldi;
  assign op_dec_o               = out_q.op_dec;
  assign op_nop_o               = out_q.op_nop;
  assign illegal_o              = out_q.illegal;
`ifdef CPU_DECODE_INC_EN
  assign op_inc_o               = inc_q;
`endif

endmodule

// File: tb/tb_cpu_decode.sv
// Randomized self-checking bench for cpu_decode against an instruction-level reference model.
module tb_cpu_decode;

`ifdef CPU_DECODE_INC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  rd_idx, rs_idx;
  logic [31:0] operand;
  logic        op_ldi, op_dec, op_nop, illegal;
  logic        op_inc_w;

  always #5 clk = ~clk;

  cpu_decode_if fetch_if();

  cpu_decode dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .fetch                  (fetch_if),
    .stall_i                (stall),
    .flush_i                (flush),
    .register_read_index_o  (rs_idx),
    .register_write_index_o (rd_idx),
    .operand_o              (operand),
    .op_ldi_o               (op_ldi),
    .op_dec_o               (op_dec),
    .op_nop_o               (op_nop),
`ifdef CPU_DECODE_INC_EN
    .op_inc_o               (op_inc_w),
`endif
    .illegal_o              (illegal)
  );

`ifndef CPU_DECODE_INC_EN
  assign op_inc_w = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int ldi_seen = 0;

  // Reference model: halfwords of the instruction in progress, and the expected outputs.
  logic [15:0] partial[$];
  logic        e_ldi, e_dec, e_inc, e_nop, e_ill;
  logic [3:0]  e_rd, e_rs;
  logic [31:0] e_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    partial.delete();
    e_ldi = 1'b0; e_dec = 1'b0; e_inc = 1'b0; e_nop = 1'b1; e_ill = 1'b0;
    e_rd = 4'd0; e_rs = 4'd0; e_op = 32'd0;
  endtask

  task automatic model_step(input logic acc, input logic fl, input logic [15:0] w);
    logic [15:0] first;
    e_ldi = 1'b0; e_dec = 1'b0; e_inc = 1'b0; e_ill = 1'b0; e_nop = 1'b1;
    if (fl) begin
      partial.delete();
    end else if (acc) begin
      partial.push_back(w);
      first = partial[0];
      if (first[15:8] == 8'h01) begin
        if (partial.size() == 3) begin
          e_ldi = 1'b1; e_nop = 1'b0;
          e_rd  = first[7:4]; e_rs = first[7:4];
          e_op  = {partial[1], partial[2]};
          partial.delete();
        end
      end else begin
        partial.delete();
        if (w[15:8] == 8'h0f) begin
          e_nop = 1'b1;
        end else if (w[15:12] == 4'h9 || (INC_EN && w[15:12] == 4'h8)) begin
          e_dec = (w[15:12] == 4'h9);
          e_inc = (w[15:12] == 4'h8);
          e_nop = 1'b0;
          e_rd  = w[11:8]; e_rs = w[11:8];
          e_op  = {24'd0, w[7:0]};
        end else begin
          e_ill = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    chk("op_ldi", 32'(op_ldi), 32'(e_ldi));
    chk("op_dec", 32'(op_dec), 32'(e_dec));
    chk("op_inc", 32'(op_inc_w), 32'(e_inc));
    chk("op_nop", 32'(op_nop), 32'(e_nop));
    chk("illegal", 32'(illegal), 32'(e_ill));
    chk("write_idx", 32'(rd_idx), 32'(e_rd));
    chk("read_idx", 32'(rs_idx), 32'(e_rs));
    chk("operand", operand, e_op);
    chk("one_hot", 32'(op_ldi) + 32'(op_dec) + 32'(op_nop) + 32'(op_inc_w), 32'd1);
  endtask

  // One cycle: drive after a falling edge, expect results at the next falling edge.
  task automatic step(input logic v, input logic [15:0] w, input logic st, input logic fl);
    fetch_if.insn_valid = v;
    fetch_if.insn       = w;
    stall               = st;
    flush               = fl;
    #1;
    chk("insn_ready", 32'(fetch_if.insn_ready), 32'(!st && !fl));
    model_step(v && !st && !fl, fl, w);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    if (op_ldi) ldi_seen++;
  endtask

  task automatic pulse_reset();
    fetch_if.insn_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_nop", 32'(op_nop), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ready", 32'(fetch_if.insn_ready), 32'd0);
    chk("rst_ldi", 32'(op_ldi), 32'd0);
    chk("rst_operand", operand, 32'd0);
    chk("rst_widx", 32'(rd_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [15:0] rw;

  initial begin
    fetch_if.insn_valid = 1'b0;
    fetch_if.insn       = 16'h0000;
    model_reset();
    pulse_reset();

    // ldi.l r3, 0xDEADBEEF
    step(1'b1, 16'h0130, 1'b0, 1'b0);
    chk("ldi_p1_nop", 32'(op_nop), 32'd1);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ldi_p2_nop", 32'(op_nop), 32'd1);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("ldi_strobe", 32'(op_ldi), 32'd1);
    chk("ldi_widx", 32'(rd_idx), 32'd3);
    chk("ldi_operand", operand, 32'hDEADBEEF);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("ldi_one_cycle", 32'(op_ldi), 32'd0);
    chk("hold_operand", operand, 32'hDEADBEEF);

    // dec r5, 5
    step(1'b1, 16'h9505, 1'b0, 1'b0);
    chk("dec_strobe", 32'(op_dec), 32'd1);
    chk("dec_widx", 32'(rd_idx), 32'd5);
    chk("dec_operand", operand, 32'h00000005);

    // Flush discards a partial ldi.l
    ldi_seen = 0;
    step(1'b1, 16'h0120, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 1'b1, 1'b1);
    step(1'b1, 16'h9201, 1'b0, 1'b0);
    chk("flush_dec", 32'(op_dec), 32'd1);
    chk("flush_widx", 32'(rd_idx), 32'd2);
    chk("flush_operand", operand, 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("flush_no_ldi", 32'(ldi_seen), 32'd0);

    // Stall holds a valid halfword, decoded exactly once after release
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h9703, 1'b1, 1'b0);
      chk("stall_nop", 32'(op_nop), 32'd1);
    end
    step(1'b1, 16'h9703, 1'b0, 1'b0);
    chk("stall_release_dec", 32'(op_dec), 32'd1);
    step(1'b0, 16'h9703, 1'b0, 1'b0);
    chk("stall_once", 32'(op_dec), 32'd0);

    // Illegal pulses for one cycle
    step(1'b1, 16'hFF00, 1'b0, 1'b0);
    chk("illegal_pulse", 32'(illegal), 32'd1);
    chk("illegal_nop", 32'(op_nop), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("illegal_one_cycle", 32'(illegal), 32'd0);

    step(1'b1, 16'h8407, 1'b0, 1'b0);
`ifdef CPU_DECODE_INC_EN
    chk("inc_strobe", 32'(op_inc_w), 32'd1);
    chk("inc_widx", 32'(rd_idx), 32'd4);
    chk("inc_operand", operand, 32'd7);
`else
    chk("inc_illegal", 32'(illegal), 32'd1);
`endif

    // Reset mid-ldi loses the partial immediate
    step(1'b1, 16'h0150, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    pulse_reset();
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("post_reset_illegal", 32'(illegal), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: rw = {8'h01, 8'($urandom)};
        1: rw = {4'h9, 12'($urandom)};
        2: rw = {8'h0f, 8'($urandom)};
        3: rw = {4'h8, 12'($urandom)};
        default: rw = 16'($urandom);
      endcase
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step($urandom_range(0, 3) != 0, rw, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
